// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
// States, opcode/funct codes, aluop and alucontrol values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: aluop + funct -> alucontrol (combinational).
// Ports: aluop[1:0], funct[5:0] in; alucontrol[2:0] out.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS core (optional BNE: MC_BNE_EN).
// In: clk, reset, op, funct, zero, mem_ready. Out: datapath selects,
// strobes (memwrite, irwrite, regwrite, pcen), illegal_op, state_o.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_ONLY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t     state, nxt;
  logic       mrdy;
  logic [1:0] aluop;
  logic       pcwrite, branch, branchn;
  logic       mw_r, ir_r, rw_r, ill_r;

  assign mrdy = (MEM_WAIT_ONLY != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = S_FETCH;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b01;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchn  = 1'b0;
    mw_r     = 1'b0;
    ir_r     = 1'b0;
    rw_r     = 1'b0;
    ill_r    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_r    = mrdy;
        pcwrite = mrdy;
        nxt     = mrdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW): nxt = S_MEMADR;
          (op == OP_RTYPE): nxt = S_RTYPEEX;
          (op == OP_BEQ):   nxt = S_BEQEX;
          (op == OP_ADDI):  nxt = S_ADDIEX;
          (op == OP_J):     nxt = S_JUMP;
`ifdef MC_BNE_EN
          (op == OP_BNE):   nxt = S_BNEEX;
`endif
          default: begin
            nxt   = S_FETCH;
            ill_r = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        unique case (1'b1)
          (op == OP_LW): nxt = S_MEMRD;
          (op == OP_SW): nxt = S_MEMWR;
          default:       nxt = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        iord = 1'b1;
        nxt  = mrdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        rw_r     = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mw_r = 1'b1;
        nxt  = mrdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        aluop   = ALUOP_FUNCT;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        regdst = 1'b1;
        rw_r   = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branchn = 1'b1;
      end
`endif
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: rw_r = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are killed combinationally so nothing writes while reset is high.
  assign memwrite   = ~reset & mw_r;
  assign irwrite    = ~reset & ir_r;
  assign regwrite   = ~reset & rw_r;
  assign illegal_op = ~reset & ill_r;
  assign pcen       = ~reset & (pcwrite | (branch & zero) | (branchn & ~zero));
  assign state_o    = state;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed self-checking bench for mc_main_ctrl.
// Walks J, LW (with stalls), R-type, ADDI, BEQ, BNE/illegal, SW+reset.
module tb_mc_main_ctrl;
  import mc_pkg::*;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  int tests = 0;
  int fails = 0;

  mc_main_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic mr, input logic [3:0] st,
                     input string tag);
    mem_ready = mr;
    @(negedge clk);
    check(tag, 8'(state_o), 8'(st));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    op = OP_J; funct = 6'd0;
    repeat (3) begin
      @(negedge clk);
      check("rst_irwrite", 8'(irwrite), 8'd0);
      check("rst_pcen", 8'(pcen), 8'd0);
      check("rst_state", 8'(state_o), 8'd0);
      check("rst_alusrcb", 8'(alusrcb), 8'd1);
      check("rst_aluctl", 8'(alucontrol), 8'd2);
    end
    reset = 1'b0;
    #1;
    check("rel_irwrite", 8'(irwrite), 8'd1);
    check("rel_pcen", 8'(pcen), 8'd1);
    check("rel_alusrcb", 8'(alusrcb), 8'd1);
    check("rel_state", 8'(state_o), 8'd0);
    adv();
    // J
    cyc(1'b1, 4'd1, "j_dec"); adv();
    cyc(1'b1, 4'd11, "j_jump");
    check("j_pcen", 8'(pcen), 8'd1);
    check("j_pcsrc", 8'(pcsrc), 8'd2);
    adv();
    // LW with stalls in FETCH and MEMRD
    op = OP_LW;
    cyc(1'b0, 4'd0, "lw_f0");
    check("lw_f0_irwrite", 8'(irwrite), 8'd0);
    check("lw_f0_pcen", 8'(pcen), 8'd0);
    adv();
    cyc(1'b0, 4'd0, "lw_f1"); adv();
    cyc(1'b1, 4'd0, "lw_f2");
    check("lw_f2_irwrite", 8'(irwrite), 8'd1);
    adv();
    cyc(1'b1, 4'd1, "lw_dec");
    check("lw_dec_alusrcb", 8'(alusrcb), 8'd3);
    adv();
    cyc(1'b1, 4'd2, "lw_adr");
    check("lw_adr_alusrcb", 8'(alusrcb), 8'd2);
    check("lw_adr_alusrca", 8'(alusrca), 8'd1);
    adv();
    cyc(1'b0, 4'd3, "lw_rd0");
    check("lw_rd_iord", 8'(iord), 8'd1);
    check("lw_rd_regwrite", 8'(regwrite), 8'd0);
    adv();
    cyc(1'b0, 4'd3, "lw_rd1"); adv();
    cyc(1'b1, 4'd3, "lw_rd2"); adv();
    cyc(1'b1, 4'd4, "lw_wb");
    check("lw_wb_regwrite", 8'(regwrite), 8'd1);
    check("lw_wb_memtoreg", 8'(memtoreg), 8'd1);
    adv();
    // R-type SUB
    op = OP_RTYPE; funct = F_SUB;
    cyc(1'b1, 4'd0, "sub_f");
    check("sub_f_regwrite", 8'(regwrite), 8'd0);
    adv();
    cyc(1'b1, 4'd1, "sub_dec"); adv();
    cyc(1'b1, 4'd6, "sub_ex");
    check("sub_aluctl", 8'(alucontrol), 8'd6);
    check("sub_alusrcb", 8'(alusrcb), 8'd0);
    adv();
    cyc(1'b1, 4'd7, "sub_wb");
    check("sub_regdst", 8'(regdst), 8'd1);
    check("sub_regwrite", 8'(regwrite), 8'd1);
    adv();
    // R-type AND and SLT
    funct = F_AND;
    cyc(1'b1, 4'd0, "and_f"); adv();
    cyc(1'b1, 4'd1, "and_dec"); adv();
    cyc(1'b1, 4'd6, "and_ex");
    check("and_aluctl", 8'(alucontrol), 8'd0);
    funct = F_SLT; #1;
    check("slt_aluctl", 8'(alucontrol), 8'd7);
    adv();
    cyc(1'b1, 4'd7, "and_wb"); adv();
    // ADDI
    op = OP_ADDI;
    cyc(1'b1, 4'd0, "addi_f"); adv();
    cyc(1'b1, 4'd1, "addi_dec"); adv();
    cyc(1'b1, 4'd9, "addi_ex");
    check("addi_alusrcb", 8'(alusrcb), 8'd2);
    check("addi_aluctl", 8'(alucontrol), 8'd2);
    adv();
    cyc(1'b1, 4'd10, "addi_wb");
    check("addi_regwrite", 8'(regwrite), 8'd1);
    check("addi_regdst", 8'(regdst), 8'd0);
    adv();
    // BEQ taken / not taken
    op = OP_BEQ; zero = 1'b1;
    cyc(1'b1, 4'd0, "beq1_f"); adv();
    cyc(1'b1, 4'd1, "beq1_dec");
    check("beq1_dec_pcen", 8'(pcen), 8'd0);
    adv();
    cyc(1'b1, 4'd8, "beq1_ex");
    check("beq1_pcen", 8'(pcen), 8'd1);
    check("beq1_pcsrc", 8'(pcsrc), 8'd1);
    check("beq1_aluctl", 8'(alucontrol), 8'd6);
    adv();
    zero = 1'b0;
    cyc(1'b1, 4'd0, "beq0_f"); adv();
    cyc(1'b1, 4'd1, "beq0_dec"); adv();
    cyc(1'b1, 4'd8, "beq0_ex");
    check("beq0_pcen", 8'(pcen), 8'd0);
    adv();
    // BNE
    op = OP_BNE;
    cyc(1'b1, 4'd0, "bne_f"); adv();
`ifdef MC_BNE_EN
    cyc(1'b1, 4'd1, "bne_dec");
    check("bne_dec_ill", 8'(illegal_op), 8'd0);
    adv();
    cyc(1'b1, 4'd12, "bne_ex");
    check("bne_pcen_z0", 8'(pcen), 8'd1);
    zero = 1'b1; #1;
    check("bne_pcen_z1", 8'(pcen), 8'd0);
    zero = 1'b0;
    adv();
`else
    cyc(1'b1, 4'd1, "bne_dec");
    check("bne_ill", 8'(illegal_op), 8'd1);
    adv();
`endif
    // Illegal opcode
    op = 6'b111111;
    cyc(1'b1, 4'd0, "ill_f"); adv();
    cyc(1'b1, 4'd1, "ill_dec");
    check("ill_pulse", 8'(illegal_op), 8'd1);
    check("ill_regwrite", 8'(regwrite), 8'd0);
    check("ill_pcen", 8'(pcen), 8'd0);
    check("ill_memwrite", 8'(memwrite), 8'd0);
    check("ill_irwrite", 8'(irwrite), 8'd0);
    adv();
    cyc(1'b0, 4'd0, "ill_back");
    check("ill_clear", 8'(illegal_op), 8'd0);
    adv();
    // SW interrupted by reset in MEMWR
    op = OP_SW;
    cyc(1'b1, 4'd0, "sw_f"); adv();
    cyc(1'b1, 4'd1, "sw_dec"); adv();
    cyc(1'b1, 4'd2, "sw_adr"); adv();
    cyc(1'b0, 4'd5, "sw_wr");
    check("sw_memwrite", 8'(memwrite), 8'd1);
    check("sw_iord", 8'(iord), 8'd1);
    #1 reset = 1'b1;
    #1;
    check("sw_rst_memwrite", 8'(memwrite), 8'd0);
    check("sw_rst_state", 8'(state_o), 8'd0);
    adv();
    reset = 1'b0;
    cyc(1'b0, 4'd0, "sw_after");
    check("sw_after_memwrite", 8'(memwrite), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
